// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: one half-adder pair processes one bit per clock, LSB first.
// Optional signed-overflow output is enabled by defining SERIAL_ADD_OVF_EN.
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] res_r;
  logic [CW-1:0]    cnt_r;
  logic             carry_r;
  logic             busy_r;
  logic             done_r;
  logic [WIDTH-1:0] sum_r;
  logic             cout_r;
  logic [1:0]       ha0_s;
  logic [1:0]       ha1_s;
  logic             bit_s;
  logic             carry_s;
  logic             last_s;
  logic             accept_s;

  // Returns {carry, sum} of a single half adder.
  function automatic logic [1:0] half_add(input logic x, input logic y);
    return {x & y, x ^ y};
  endfunction

  // Bit datapath and next-state decode.
  always_comb begin
    state_s  = state_r;
    accept_s = 1'b0;
    ha0_s    = half_add(a_r[0], b_r[0]);
    ha1_s    = half_add(ha0_s[0], carry_r);
    bit_s    = ha1_s[0];
    carry_s  = ha0_s[1] | ha1_s[1];
    last_s   = (cnt_r == LAST_BIT);
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s  = RUN;
          accept_s = 1'b1;
        end else begin
          state_s  = IDLE;
        end
      end
      RUN: begin
        if (last_s) begin
          state_s = DONE;
        end else begin
          state_s = RUN;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State, operand shifters, carry, counter and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      a_r     <= '0;
      b_r     <= '0;
      res_r   <= '0;
      cnt_r   <= '0;
      carry_r <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      sum_r   <= '0;
      cout_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      busy_r  <= (state_s != IDLE);
      done_r  <= (state_s == DONE);
      if (accept_s) begin
        a_r     <= a;
        b_r     <= b;
        carry_r <= cin;
        cnt_r   <= '0;
      end else if (state_r == RUN) begin
        a_r     <= {1'b0, a_r[WIDTH-1:1]};
        b_r     <= {1'b0, b_r[WIDTH-1:1]};
        res_r   <= {bit_s, res_r[WIDTH-1:1]};
        carry_r <= carry_s;
        cnt_r   <= cnt_r + CW'(1);
        if (last_s) begin
          sum_r  <= {bit_s, res_r[WIDTH-1:1]};
          cout_r <= carry_s;
        end else begin
          sum_r  <= sum_r;
          cout_r <= cout_r;
        end
      end else begin
        a_r     <= a_r;
        b_r     <= b_r;
        carry_r <= carry_r;
        cnt_r   <= cnt_r;
      end
    end
  end

`ifdef SERIAL_ADD_OVF_EN
  logic ovf_r;

  // Signed overflow: carry into the MSB differs from carry out of it.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_r <= 1'b0;
    end else if ((state_r == RUN) && last_s) begin
      ovf_r <= carry_r ^ carry_s;
    end else begin
      ovf_r <= ovf_r;
    end
  end

  assign ovf = ovf_r;
`endif

  assign busy = busy_r;
  assign done = done_r;
  assign sum  = sum_r;
  assign cout = cout_r;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed self-checking bench for serial_adder_ctrl at WIDTH=8.
// Define SERIAL_ADD_OVF_EN to also check the overflow output.
module tb_serial_adder_ctrl;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef SERIAL_ADD_OVF_EN
  logic             ovf;
`endif

  int n_vec;
  int n_err;

  serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
`ifdef SERIAL_ADD_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while (busy && guard < 40) begin
      tick();
      guard++;
    end
    check("idle_timeout", 32'(busy), 32'd0);
  endtask

  // One complete addition with latency, result and handshake checks.
  task automatic run_add(input logic [7:0] av, input logic [7:0] bv, input logic cv,
                         input logic [7:0] exp_sum, input logic exp_cout, input logic exp_ovf);
    int cyc;
    wait_idle();
    a = av; b = bv; cin = cv; start = 1'b1;
    tick();
    start = 1'b0;
    a = ~av; b = ~bv; cin = ~cv;
    check("busy_after_accept", 32'(busy), 32'd1);
    cyc = 0;
    while (cyc < 20) begin
      tick();
      cyc++;
      if (done) break;
    end
    check("latency", 32'(cyc), 32'd8);
    check("sum", 32'(sum), 32'(exp_sum));
    check("cout", 32'(cout), 32'(exp_cout));
`ifdef SERIAL_ADD_OVF_EN
    check("ovf", 32'(ovf), 32'(exp_ovf));
`else
    if (exp_ovf) begin
    end
`endif
    tick();
    check("done_one_cycle", 32'(done), 32'd0);
    check("busy_drop", 32'(busy), 32'd0);
    check("sum_hold", 32'(sum), 32'(exp_sum));
  endtask

  initial begin
    int n_done;
    int n_acc;
    int t_acc[2];
    logic prev_busy;

    n_vec = 0; n_err = 0;
    rst = 1'b1; start = 1'b0; a = 8'h00; b = 8'h00; cin = 1'b0;
    tick(); tick();
    rst = 1'b0;
    repeat (5) tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sum", 32'(sum), 32'h00);
    check("rst_cout", 32'(cout), 32'd0);

    run_add(8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 1'b0);
    run_add(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    run_add(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);
    run_add(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    run_add(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
    run_add(8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0);
    run_add(8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 1'b0);

    // Second start during RUN must be ignored.
    a = 8'h01; b = 8'h01; cin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    n_done = 0;
    for (int i = 1; i <= 20; i++) begin
      if (i == 3) begin
        a = 8'hAA; b = 8'h55; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      tick();
      if (done) n_done++;
    end
    start = 1'b0;
    check("ignore_done_count", 32'(n_done), 32'd1);
    check("ignore_sum", 32'(sum), 32'h02);
    check("ignore_cout", 32'(cout), 32'd0);

    // Start held high: accepts every WIDTH+2 cycles.
    wait_idle();
    a = 8'h01; b = 8'h02; cin = 1'b0; start = 1'b1;
    prev_busy = busy;
    n_acc = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (busy && !prev_busy && n_acc < 2) begin
        t_acc[n_acc] = i;
        n_acc++;
      end
      prev_busy = busy;
    end
    start = 1'b0;
    check("hold_accepts", 32'(n_acc), 32'd2);
    if (n_acc == 2) check("hold_spacing", 32'(t_acc[1] - t_acc[0]), 32'd10);
    wait_idle();
    check("hold_sum", 32'(sum), 32'h03);

    // Reset mid-operation aborts and clears.
    a = 8'h0F; b = 8'h0F; cin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_sum", 32'(sum), 32'h00);
    check("abort_done", 32'(done), 32'd0);
    n_done = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done) n_done++;
    end
    check("abort_no_done", 32'(n_done), 32'd0);
    run_add(8'h0F, 8'h0F, 1'b0, 8'h1E, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/serial_adder_ctrl.md
# serial_adder_ctrl

Bit-serial addition controller that uses a single 1-bit adder datapath, built from two `half_adder` stages plus an OR for carry, to add two WIDTH-bit operands over WIDTH clock cycles, LSB first. It owns the operand shift registers, carry flip-flop, bit counter and start/done handshake. It is the sequencing layer that lets one half-adder-based cell replace a WIDTH-bit ripple adder where area matters more than latency.

## Interface
Parameters:
- `WIDTH`, default 8: operand and result width in bits; legal range 2–32.

Ports:
- `clk` (input, 1): single clock; all state updates on rising edge.
- `rst` (input, 1): synchronous, active-high reset.
- `start` (input, 1): request a new addition; sampled only in IDLE.
- `a` (input, WIDTH): operand A; captured on the accepting edge.
- `b` (input, WIDTH): operand B; captured on the accepting edge.
- `cin` (input, 1): carry-in; captured on the accepting edge.
- `busy` (output, 1): high in RUN and DONE.
- `done` (output, 1): one-cycle pulse when the result is valid.
- `sum` (output, WIDTH): registered result; holds its value until the next completion.
- `cout` (output, 1): registered carry-out of the MSB.
- `ovf` (output, 1): signed overflow. Present only with `SERIAL_ADD_OVF_EN`.

## Operation
- Reset is synchronous and active-high: state=IDLE, `busy`=0, `done`=0, `sum`=0, `cout`=0, `ovf`=0, bit counter=0, carry flip-flop=0, shift registers=0.
- State machine IDLE → RUN → DONE → IDLE.
  - IDLE, with `start`=1 at an edge: load `a` and `b` into the shift registers, load `cin` into the carry flip-flop, set counter=0, go to RUN.
  - IDLE, with `start`=0: stay in IDLE.
  - RUN, each edge:
    - Bit datapath: first half adder = a[0]^b[0], with carry a[0]&b[0]. Second half adder combines that result with the carry flip-flop. New carry = OR of the two half-adder carries.
    - The result bit shifts into the internal result register at the MSB end.
    - Operand registers shift right by 1.
    - Counter increments.
    - When counter==WIDTH-1 on this edge: copy the result register (including this bit) to `sum`, the new carry to `cout`, go to DONE.
  - DONE, one cycle: `done`=1, then go to IDLE unconditionally.
- `start` is ignored in RUN and DONE. It is not queued. The earliest re-accept is the edge after DONE.
- `a`, `b` and `cin` may change freely after the accepting edge.
- Arithmetic: {`cout`, `sum`} = a + b + cin, modulo 2^(WIDTH+1). Unsigned.
- Reset asserted mid-operation:
  - Aborts immediately on that edge and returns all outputs to reset values.
  - No `done` pulse is produced for the aborted operation.
  - The previous `sum` is cleared.

## Timing
- Accepting edge E0: `busy`=1 from E0.
- Bit k is processed on edge E(k+1), for k = 0..WIDTH-1.
- `sum`, `cout` and `ovf` update on edge E(WIDTH). `done`=1 for the cycle between E(WIDTH) and E(WIDTH+1).
- Latency from accept to `done`: WIDTH cycles.
- `busy`=0 from E(WIDTH+1). Throughput: one addition per WIDTH+2 cycles with `start` held high.
- `done` is never high for more than one consecutive cycle.
- `sum` and `cout` are stable at all times except the completion edge.

## Configuration
- `SERIAL_ADD_OVF_EN` defined:
  - Port `ovf` exists.
  - On the MSB edge, `ovf` = (carry into MSB) XOR (carry out of MSB), registered together with `sum`.
  - Reset value 0; holds until the next completion.
- `SERIAL_ADD_OVF_EN` undefined:
  - Port `ovf` and its register are absent.
  - All other behaviour and timing are identical.

## Test plan
- Use WIDTH=8 for all cases. After reset with `start`=0 for 5 cycles: `busy`=0, `done`=0, `sum`=0x00, `cout`=0.
- a=0x35, b=0x4A, cin=0, pulse `start` → `done` 8 cycles after the accepting edge, `sum`=0x7F, `cout`=0, `busy` drops the next cycle.
- a=0xFF, b=0x01, cin=0 → `sum`=0x00, `cout`=1. Then a=0xFF, b=0xFF, cin=1 → `sum`=0xFF, `cout`=1.
- With `SERIAL_ADD_OVF_EN`:
  - a=0x7F, b=0x01 → `sum`=0x80, `ovf`=1.
  - a=0x80, b=0x80 → `sum`=0x00, `cout`=1, `ovf`=1.
  - a=0x10, b=0x20 → `ovf`=0.
- Start a=0x01, b=0x01, then pulse `start` with a=0xAA, b=0x55 at cycle 3 (during RUN) → second request ignored, result `sum`=0x02, exactly one `done` pulse. Holding `start` high continuously gives accepts spaced exactly 10 cycles apart.
- Assert `rst` at cycle 4 of an addition of 0x0F+0x0F → next cycle `busy`=0, `sum`=0x00, no `done`. A following addition of 0x0F+0x0F → `sum`=0x1E, `cout`=0.
